// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg: shared states, address windows and glyph constants for the scroll display
package hex_scroll_pkg;
  typedef enum logic [1:0] {S_WAIT, S_FETCH, S_SHIFT} state_t;
  localparam int MODE0_START = 0;
  localparam int MODE0_END   = 5;
  localparam int MODE1_START = 6;
  localparam int MODE1_END   = 10;
  localparam int MODE2_START = 0;
  localparam int MODE2_END   = 10;
  localparam logic [6:0] BLANK = 7'h7F;
  function automatic logic [1:0] decode_mode(input logic [1:0] sw);
    return sw[1] ? 2'd2 : sw[0] ? 2'd1 : 2'd0;
  endfunction
  function automatic int win_start(input logic [1:0] m);
    return m == 2'd1 ? MODE1_START : m == 2'd2 ? MODE2_START : MODE0_START;
  endfunction
  function automatic int win_end(input logic [1:0] m);
    return m == 2'd1 ? MODE1_END : m == 2'd2 ? MODE2_END : MODE0_END;
  endfunction
endpackage

// File: rtl/hex_scroll_ctrl_tick_gen.sv
// tick_gen: step prescaler that freezes while held and restarts on clear
module tick_gen #(
  parameter int CLK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = !hold && cnt == CW'(CLK_DIV - 1);
  // count while running, hold value while held, wrap on tick or clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (!hold) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: fetches glyphs from the message ROM and scrolls them across HEX0..HEX3
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000,
  parameter int ADDR_W  = 4,
  parameter int SEG_W   = 7
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [1:0]        SW,
  input  logic              PAUSE,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [SEG_W-1:0]  ROM_DATA,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic              WRAP
);
  localparam logic [SEG_W-1:0] BLK = SEG_W'(BLANK);
  logic [1:0] sw_meta, sw_sync, mode, new_mode;
  state_t state;
  logic [ADDR_W-1:0] ptr, w_start, w_end, n_start;
  logic mode_chg, tick, hold, at_end, step_ok;
  assign new_mode = decode_mode(sw_sync);
  assign mode_chg = new_mode != mode;
  assign w_start  = ADDR_W'(win_start(mode));
  assign w_end    = ADDR_W'(win_end(mode));
  assign n_start  = ADDR_W'(win_start(new_mode));
  assign at_end   = ptr == w_end;
  assign step_ok  = ptr >= w_start && ptr < w_end;
  assign hold     = PAUSE || state != S_WAIT;
  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .clr  (mode_chg),
    .hold (hold),
    .tick (tick)
  );
  // two-flop synchronizer for the asynchronous mode switches
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) {sw_sync, sw_meta} <= '0;
    else {sw_sync, sw_meta} <= {sw_meta, SW};
  // step sequencer: mode change restarts everything, otherwise wait -> fetch -> shift
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state    <= S_WAIT;
      mode     <= 2'd0;
      ptr      <= '0;
      ROM_ADDR <= '0;
      WRAP     <= 1'b0;
      {HEX3, HEX2, HEX1, HEX0} <= {4{BLK}};
    end else if (mode_chg) begin
      state <= S_WAIT;
      mode  <= new_mode;
      ptr   <= n_start;
      WRAP  <= 1'b0;
      {HEX3, HEX2, HEX1, HEX0} <= {4{BLK}};
    end else begin
      WRAP <= 1'b0;
      case (state)
        S_WAIT: if (tick) begin
          state    <= S_FETCH;
          ROM_ADDR <= ptr;
        end
        S_FETCH: state <= S_SHIFT;
        S_SHIFT: begin
          state <= S_WAIT;
          {HEX3, HEX2, HEX1, HEX0} <= {HEX2, HEX1, HEX0, ROM_DATA};
          ptr   <= step_ok ? ptr + 1'b1 : w_start;
          WRAP  <= at_end;
        end
        default: state <= S_WAIT;
      endcase
    end
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb_hex_scroll_ctrl: randomized and directed checks against a step-progress reference model
module tb_hex_scroll_ctrl;
  localparam int CLK_DIV = 4;
  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [1:0] SW;
  logic       PAUSE;
  logic [3:0] ROM_ADDR;
  logic [6:0] ROM_DATA;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       WRAP;
  int tests = 0;
  int fails = 0;

  hex_scroll_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(4), .SEG_W(7)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SW(SW), .PAUSE(PAUSE),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .WRAP(WRAP)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) ROM_DATA <= 7'h40 | {3'b000, ROM_ADDR};

  function automatic int dec(input logic [1:0] s);
    return s[1] ? 2 : s[0] ? 1 : 0;
  endfunction
  function automatic int wst(input int m);
    return m == 1 ? 6 : 0;
  endfunction
  function automatic int wend(input int m);
    return m == 0 ? 5 : 10;
  endfunction

  // reference: m_p = progress through one step (0..CLK_DIV-1 waiting, CLK_DIV fetch, CLK_DIV+1 shift)
  logic [1:0] s1, s2;
  int m_mode, m_ptr, m_p, m_addr;
  logic m_wrap;
  logic [6:0] m_hex [4];
  always @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      s1 <= 2'b00; s2 <= 2'b00; m_mode <= 0; m_ptr <= 0; m_p <= 0; m_addr <= 0; m_wrap <= 1'b0;
      for (int i = 0; i < 4; i++) m_hex[i] <= 7'h7F;
    end else begin
      s1 <= SW;
      s2 <= s1;
      m_wrap <= 1'b0;
      if (dec(s2) != m_mode) begin
        m_mode <= dec(s2);
        m_ptr  <= wst(dec(s2));
        m_p    <= 0;
        for (int i = 0; i < 4; i++) m_hex[i] <= 7'h7F;
      end else if (m_p < CLK_DIV) begin
        if (!PAUSE) begin
          m_p <= m_p + 1;
          if (m_p == CLK_DIV - 1) m_addr <= m_ptr;
        end
      end else if (m_p == CLK_DIV) begin
        m_p <= m_p + 1;
      end else begin
        m_p <= 0;
        m_hex[3] <= m_hex[2];
        m_hex[2] <= m_hex[1];
        m_hex[1] <= m_hex[0];
        m_hex[0] <= 7'h40 | 7'(m_addr);
        m_wrap <= m_ptr == wend(m_mode);
        m_ptr  <= m_ptr == wend(m_mode) ? wst(m_mode) : m_ptr + 1;
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hex0", 32'(HEX0), 32'(m_hex[0]));
    chk("hex1", 32'(HEX1), 32'(m_hex[1]));
    chk("hex2", 32'(HEX2), 32'(m_hex[2]));
    chk("hex3", 32'(HEX3), 32'(m_hex[3]));
    chk("rom_addr", 32'(ROM_ADDR), 32'(m_addr));
    chk("wrap", 32'(WRAP), 32'(m_wrap));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      check_all();
    end
  endtask

  task automatic blank_chk(input string tag);
    chk(tag, {HEX3, HEX2, HEX1, HEX0}, {4{7'h7F}});
  endtask

  initial begin
    int n;
    SW = 2'b00; PAUSE = 1'b0; RESET_N = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    blank_chk("reset_hex");
    chk("reset_addr", 32'(ROM_ADDR), 0);
    chk("reset_wrap", 32'(WRAP), 0);
    RESET_N = 1'b1;
    // mode 0: four glyphs after 4 steps of CLK_DIV+2 edges, wrap on sixth shift
    cyc(24);
    chk("t1_hex", {HEX3, HEX2, HEX1, HEX0}, {7'h40, 7'h41, 7'h42, 7'h43});
    cyc(12);
    chk("t1_wrap", 32'(WRAP), 1);
    chk("t1_addr5", 32'(ROM_ADDR), 5);
    cyc(1);
    chk("t1_wrap_width", 32'(WRAP), 0);
    // mode 1 then mode 2 (priority on SW[1])
    SW = 2'b01;
    cyc(80);
    SW = 2'b11;
    cyc(150);
    // pause in the middle of a wait phase
    n = 0;
    while (n < 20 && !(m_p > 0 && m_p < CLK_DIV)) begin cyc(1); n++; end
    chk("t4_reach_wait", 32'(n < 20), 1);
    PAUSE = 1'b1;
    cyc(20);
    PAUSE = 1'b0;
    cyc(20);
    // mode change while a fetch is in flight
    SW = 2'b00;
    cyc(40);
    n = 0;
    while (n < 20 && m_p != CLK_DIV) begin cyc(1); n++; end
    chk("t5_reach_fetch", 32'(n < 20), 1);
    SW = 2'b01;
    cyc(3);
    blank_chk("t5_blank");
    cyc(CLK_DIV);
    chk("t5_first_addr", 32'(ROM_ADDR), 6);
    cyc(30);
    // asynchronous reset during the shift state
    n = 0;
    while (n < 20 && m_p != CLK_DIV + 1) begin cyc(1); n++; end
    chk("t6_reach_shift", 32'(n < 20), 1);
    #3 RESET_N = 1'b0;
    #1;
    blank_chk("t6_async_blank");
    chk("t6_async_addr", 32'(ROM_ADDR), 0);
    check_all();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    cyc(60);
    // randomized pause and mode activity
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if ($urandom_range(0, 19) == 0) PAUSE = ~PAUSE;
      if ($urandom_range(0, 99) == 0) SW = 2'($urandom_range(0, 3));
    end
    PAUSE = 1'b0;
    cyc(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
